// File: rtl/image_streamer.sv
// ---------------------------------------------------------------------------
// image_streamer
//   Holds one WIDTH x HEIGHT frame of unsigned pixels in an internal
//   synchronous-read RAM. It streams the frame in raster order as a
//   pixel/valid pair into the first convolution stage. The consumer has no
//   backpressure. The host loads the frame through the write port while the
//   block is idle and then pulses start.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   wr_en/addr/data frame-buffer write port (linear index row*WIDTH+col)
//   wr_err          one-cycle pulse when a write is rejected (busy or out of range)
//   start           begin streaming one frame (ignored while busy)
//   pause           while high, no new RAM reads are issued
//   busy            high from the cycle after start is accepted to the end of frame
//   pixel_out       streamed pixel, qualified by valid_out
//   valid_out       one cycle per pixel, strictly ascending addresses
//   frame_done      coincides with valid_out of the last pixel
// ---------------------------------------------------------------------------
module image_streamer #(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10,
    parameter int GAP       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_err,
    input  logic                 start,
    input  logic                 pause,
    output logic                 busy,
    output logic [DATA_BITS-1:0] pixel_out,
    output logic                 valid_out,
    output logic                 frame_done
);

    localparam int FRAME = WIDTH * HEIGHT;
    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GAP_W = (GAP    > 1) ? $clog2(GAP)    : 1;
    localparam logic [ADDR_BITS:0] FRAME_A = (ADDR_BITS+1)'(FRAME);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   rd_issue, start_acc, at_last, gap_end, wr_ok;
    logic [DATA_BITS-1:0]   mem [0:(1<<ADDR_BITS)-1];

    // Position of the next read is tracked as row/col so the final pixel is
    // recognised without a wide address compare.
    assign at_last = (row == ROW_W'(HEIGHT-1)) && (col == COL_W'(WIDTH-1));
    assign gap_end = (gap_cnt == GAP_W'(GAP-1));

    // Writes are only taken while idle and inside the frame; the RAM is deeper
    // than the frame, so the range check is what prevents stray addresses
    // from landing in unused words that a later change might alias.
    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < FRAME_A);

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        start_acc = 1'b0;
        case (state)
            // busy is still high in the frame_done cycle, so a start there
            // is ignored even though the FSM is already back in IDLE.
            S_IDLE: begin
                if (start && !busy) begin
                    start_acc = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!pause) begin
                    rd_issue = 1'b1;
                    if (at_last)
                        state_nxt = S_IDLE;
                    else if (GAP > 0)
                        state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end)
                    state_nxt = S_STREAM;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Read issue -> output stage: valid and RAM data register together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            col        <= '0;
            row        <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            wr_err     <= 1'b0;
            pixel_out  <= '0;
        end else begin
            valid_out  <= rd_issue;
            frame_done <= rd_issue && at_last;
            wr_err     <= wr_en && !wr_ok;
            if (rd_issue)
                pixel_out <= mem[rd_addr];

            // busy falls on the edge after the last pixel is presented.
            if (start_acc)
                busy <= 1'b1;
            else if (frame_done)
                busy <= 1'b0;

            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;

            if (start_acc) begin
                rd_addr <= '0;
                col     <= '0;
                row     <= '0;
            end else if (rd_issue) begin
                rd_addr <= rd_addr + 1'b1;
                if (col == COL_W'(WIDTH-1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

endmodule
